// File: rtl/multi_proto_tx_engine.sv
// multi_proto_tx_engine
//   FIFO-buffered serial transmitter. Each queued word carries a protocol tag
//   (0 = SPI master, 1 = UART transmit), so both protocols share one queue and
//   are sent strictly in write order.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   wr_en, wr_prot, wr_dat   host push of {tag, payload}
//   spi_mode                 {CPOL, CPHA}, captured when a word is popped
//   parity_en                UART even-parity enable, captured when popped
//   clr_err                  clears ovf_err (a same-cycle overflow wins)
//   fifo_full/empty/count    queue status
//   busy                     FSM not in IDLE
//   cs, sclk, mosi           SPI pins (cs active-low, MSB first)
//   uart_tx                  UART line (idle high, LSB first)
//   spi_done, uart_done      one-cycle completion pulses
//   ovf_err                  sticky: a write was dropped on a full queue
//
// All pin outputs are registered from the current FSM state, so they trail
// the state register by one cycle; done pulses land in the first IDLE cycle.
module multi_proto_tx_engine #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int SPI_DIV    = 4,
  parameter int UART_DIV   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic                          wr_prot,
  input  logic [DATA_W-1:0]             wr_dat,
  input  logic [1:0]                    spi_mode,
  input  logic                          parity_en,
  input  logic                          clr_err,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          cs,
  output logic                          sclk,
  output logic                          mosi,
  output logic                          uart_tx,
  output logic                          spi_done,
  output logic                          uart_done,
  output logic                          ovf_err
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int DIV_MAX = (SPI_DIV > UART_DIV) ? SPI_DIV : UART_DIV;
  localparam int DIV_W   = $clog2(DIV_MAX);
  localparam int CW      = $clog2(2 * DATA_W);
  localparam int IW      = $clog2(DATA_W);

  localparam logic [DIV_W-1:0] SPI_LAST  = DIV_W'(SPI_DIV - 1);
  localparam logic [DIV_W-1:0] UART_LAST = DIV_W'(UART_DIV - 1);
  localparam logic [CW-1:0]    HALF_LAST = CW'(2 * DATA_W - 1);
  localparam logic [CW-1:0]    BIT_LAST  = CW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE, SPI_SETUP, SPI_SHIFT, SPI_HOLD, U_START, U_DATA, U_PAR, U_STOP
  } state_t;

  // ---------------- FIFO ----------------
  logic [DATA_W:0] mem [FIFO_DEPTH];   // {prot, data}
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [DATA_W:0] head;
  logic            push, pop;
  state_t          state, state_n;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_count = wr_ptr - rd_ptr;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign pop        = (state == IDLE) && !fifo_empty;
  // A pop in the same cycle frees a slot, so a write on a full queue still lands.
  assign push       = wr_en && (!fifo_full || pop);

  // NOTE: storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {wr_prot, wr_dat};
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && fifo_full && !pop) ovf_err <= 1'b1;
      else if (clr_err)               ovf_err <= 1'b0;
    end
  end

  // ---------------- FSM ----------------
  logic [DIV_W-1:0]  div_cnt, div_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [DATA_W-1:0] word;
  logic [1:0]        mode_q;
  logic              par_q;
  logic              div_last;
  logic              cs_d, sclk_d, mosi_d, tx_d, spi_done_d, uart_done_d;
  logic [IW-1:0]     spi_bit;
  int                spi_idx;

  assign busy     = (state != IDLE);
  assign div_last = (state == SPI_SETUP || state == SPI_SHIFT || state == SPI_HOLD)
                    ? (div_cnt == SPI_LAST) : (div_cnt == UART_LAST);

  // CPHA=0 presents bit k before leading edge k and advances on trailing edges;
  // CPHA=1 advances on leading edges. Past the last bit the LSB is held.
  always_comb begin
    spi_idx = mode_q[0] ? (int'(cnt) >> 1) : ((int'(cnt) + 1) >> 1);
    if (spi_idx > DATA_W - 1) spi_idx = DATA_W - 1;
    spi_bit = IW'(DATA_W - 1 - spi_idx);
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_n     = state;
    div_n       = div_last ? '0 : div_cnt + 1'b1;
    cnt_n       = cnt;
    cs_d        = 1'b1;
    sclk_d      = mode_q[1];
    mosi_d      = 1'b0;
    tx_d        = 1'b1;
    spi_done_d  = 1'b0;
    uart_done_d = 1'b0;
    case (state)
      IDLE: begin
        div_n = '0;
        cnt_n = '0;
        if (!fifo_empty) state_n = head[DATA_W] ? U_START : SPI_SETUP;
      end
      SPI_SETUP: begin
        cs_d   = 1'b0;
        mosi_d = mode_q[0] ? 1'b0 : word[DATA_W-1];
        if (div_last) state_n = SPI_SHIFT;
      end
      SPI_SHIFT: begin
        cs_d   = 1'b0;
        // Even half-periods follow a leading edge, odd ones a trailing edge.
        sclk_d = mode_q[1] ^ ~cnt[0];
        mosi_d = word[spi_bit];
        if (div_last) begin
          if (cnt == HALF_LAST) begin
            cnt_n   = '0;
            state_n = SPI_HOLD;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      SPI_HOLD: begin
        cs_d = 1'b0;
        if (div_last) begin
          state_n    = IDLE;
          spi_done_d = 1'b1;
        end
      end
      U_START: begin
        tx_d = 1'b0;
        if (div_last) state_n = U_DATA;
      end
      U_DATA: begin
        tx_d = word[cnt[IW-1:0]];
        if (div_last) begin
          if (cnt == BIT_LAST) begin
            cnt_n   = '0;
            state_n = par_q ? U_PAR : U_STOP;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      U_PAR: begin
        tx_d = ^word;
        if (div_last) state_n = U_STOP;
      end
      U_STOP: begin
        if (div_last) begin
          state_n     = IDLE;
          uart_done_d = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      cnt       <= '0;
      word      <= '0;
      mode_q    <= 2'b00;
      par_q     <= 1'b0;
      cs        <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      uart_tx   <= 1'b1;
      spi_done  <= 1'b0;
      uart_done <= 1'b0;
    end else begin
      state     <= state_n;
      div_cnt   <= div_n;
      cnt       <= cnt_n;
      if (pop) begin
        word   <= head[DATA_W-1:0];
        mode_q <= spi_mode;
        par_q  <= parity_en;
      end
      cs        <= cs_d;
      sclk      <= sclk_d;
      mosi      <= mosi_d;
      uart_tx   <= tx_d;
      spi_done  <= spi_done_d;
      uart_done <= uart_done_d;
    end
  end

endmodule

// File: tb/tb_multi_proto_tx_engine.sv
// Self-checking bench for multi_proto_tx_engine. Written words are pushed to
// an expected queue; a pin monitor decodes SPI and UART frames into an
// observed queue, and the main sequence pops and compares both.
module tb_multi_proto_tx_engine;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int SDIV  = 4;
  localparam int UDIV  = 16;

  logic          clk, rst;
  logic          wr_en, wr_prot, parity_en, clr_err;
  logic [DW-1:0] wr_dat;
  logic [1:0]    spi_mode;
  logic          fifo_full, fifo_empty, busy, cs, sclk, mosi, uart_tx;
  logic          spi_done, uart_done, ovf_err;
  logic [$clog2(DEPTH):0] fifo_count;

  multi_proto_tx_engine #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH), .SPI_DIV(SDIV), .UART_DIV(UDIV)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_prot(wr_prot), .wr_dat(wr_dat),
    .spi_mode(spi_mode), .parity_en(parity_en), .clr_err(clr_err),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
    .busy(busy), .cs(cs), .sclk(sclk), .mosi(mosi), .uart_tx(uart_tx),
    .spi_done(spi_done), .uart_done(uart_done), .ovf_err(ovf_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { bit prot; logic [DW-1:0] data; bit pen; } exp_t;
  typedef struct {
    bit prot; logic [DW-1:0] data; int len; int edges; bit par; bit stop; bit stable;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];

  int checks   = 0;
  int failures = 0;

  // Monitor state (written only by the monitor process)
  bit            spi_act, u_act, prev_sclk, u_cur, u_stable, u_par, u_stop;
  int            spi_len, spi_edges, u_off, u_nbits;
  logic [DW-1:0] spi_sh, u_data;
  int            spi_dn, uart_dn, overlap;
  bit            mon_par_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, want);
    end
  endtask

  // Pin-level monitor: SPI slave capturing on rising sclk, UART receiver
  // sampling mid-bit and checking every bit is flat for its full period.
  initial begin
    spi_act = 0; u_act = 0; prev_sclk = 0; spi_dn = 0; uart_dn = 0; overlap = 0;
    spi_len = 0; spi_edges = 0; spi_sh = '0; u_off = 0; u_nbits = 0;
    u_cur = 0; u_stable = 0; u_par = 0; u_stop = 0; u_data = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        spi_act = 0;
        u_act   = 0;
      end else begin
        if (spi_done === 1'b1)  spi_dn++;
        if (uart_done === 1'b1) uart_dn++;
        if (cs === 1'b0) begin
          if (!spi_act) begin
            spi_act = 1; spi_len = 0; spi_edges = 0; spi_sh = '0;
          end else if (sclk === 1'b1 && prev_sclk === 1'b0) begin
            spi_sh = {spi_sh[DW-2:0], mosi};
            spi_edges++;
          end
          spi_len++;
        end else if (spi_act) begin
          spi_act = 0;
          obs_q.push_back('{1'b0, spi_sh, spi_len, spi_edges, 1'b0, 1'b0, 1'b0});
        end
        if (!u_act && uart_tx === 1'b0) begin
          u_act = 1; u_off = 0; u_nbits = DW + 2 + int'(mon_par_en);
          u_stable = 1; u_data = '0; u_par = 0; u_stop = 0;
        end
        if (u_act) begin
          if (cs === 1'b0) overlap++;
          if (u_off % UDIV == 0) u_cur = uart_tx;
          else if (uart_tx !== u_cur) u_stable = 0;
          if (u_off % UDIV == UDIV / 2) begin
            if (u_off / UDIV >= 1 && u_off / UDIV <= DW) u_data[u_off / UDIV - 1] = uart_tx;
            else if (u_off / UDIV == DW + 1 && mon_par_en) u_par = uart_tx;
            if (u_off / UDIV == u_nbits - 1) u_stop = uart_tx;
          end
          u_off++;
          if (u_off == u_nbits * UDIV) begin
            u_act = 0;
            obs_q.push_back('{1'b1, u_data, 0, 0, u_par, u_stop, u_stable});
          end
        end
      end
      prev_sclk = sclk;
    end
  end

  task automatic send(input bit prot, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_prot = prot; wr_dat = d;
    exp_q.push_back('{prot, d, parity_en});
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic expect_frames(input int n);
    for (int k = 0; k < n; k++) begin
      int   waited;
      obs_t o;
      exp_t e;
      waited = 0;
      while (obs_q.size() == 0 && waited < 2000) begin
        @(negedge clk);
        waited++;
      end
      check("frame_arrived", 32'(obs_q.size() != 0), 32'd1);
      if (obs_q.size() == 0) return;
      o = obs_q.pop_front();
      check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      check("frame_prot", 32'(o.prot), 32'(e.prot));
      check("frame_data", 32'(o.data), 32'(e.data));
      if (!e.prot) begin
        check("spi_cs_low_cycles", 32'(o.len), 32'(SDIV * (2 * DW + 2)));
        check("spi_sclk_rises", 32'(o.edges), 32'(DW));
      end else begin
        check("uart_bits_flat", 32'(o.stable), 32'd1);
        check("uart_stop_bit", 32'(o.stop), 32'd1);
        if (e.pen) check("uart_parity", 32'(o.par), 32'(^e.data));
      end
    end
  endtask

  initial begin
    int base, ubase, waited;
    rst = 1'b0; wr_en = 1'b0; wr_prot = 1'b0; wr_dat = '0;
    spi_mode = 2'b00; parity_en = 1'b0; clr_err = 1'b0; mon_par_en = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_fifo_empty", 32'(fifo_empty), 32'd1);
    check("rst_fifo_full",  32'(fifo_full),  32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_cs",         32'(cs),         32'd1);
    check("rst_sclk",       32'(sclk),       32'd0);
    check("rst_mosi",       32'(mosi),       32'd0);
    check("rst_uart_tx",    32'(uart_tx),    32'd1);
    check("rst_dones",      32'({spi_done, uart_done}), 32'd0);
    check("rst_ovf",        32'(ovf_err),    32'd0);
    rst = 1'b1;
    @(negedge clk);

    // SPI mode 0, 0xA5: latency from write edge and full frame
    base = spi_dn;
    send(1'b0, 8'hA5);
    check("lat_empty_after_write", 32'(fifo_empty), 32'd0);
    check("lat_count_after_write", 32'(fifo_count), 32'd1);
    check("lat_busy_before_pop",   32'(busy),       32'd0);
    @(negedge clk);
    check("lat_busy_after_pop",    32'(busy),       32'd1);
    check("lat_empty_after_pop",   32'(fifo_empty), 32'd1);
    check("lat_cs_after_pop",      32'(cs),         32'd1);
    @(negedge clk);
    check("lat_cs_low",            32'(cs),         32'd0);
    expect_frames(1);
    repeat (4) @(negedge clk);
    check("spi_done_pulses_m0", 32'(spi_dn - base), 32'd1);

    // SPI mode 3, 0x3C: sclk idles high afterwards
    spi_mode = 2'b11;
    base = spi_dn;
    send(1'b0, 8'h3C);
    expect_frames(1);
    repeat (4) @(negedge clk);
    check("m3_sclk_idle_high", 32'(sclk), 32'd1);
    check("m3_cs_idle",        32'(cs),   32'd1);
    check("spi_done_pulses_m3", 32'(spi_dn - base), 32'd1);
    spi_mode = 2'b00;

    // UART 0x55 with even parity
    parity_en = 1'b1; mon_par_en = 1'b1;
    ubase = uart_dn;
    send(1'b1, 8'h55);
    expect_frames(1);
    repeat (4) @(negedge clk);
    check("uart_done_pulses", 32'(uart_dn - ubase), 32'd1);
    check("uart_idle_after",  32'(uart_tx), 32'd1);
    check("uart_busy_after",  32'(busy),    32'd0);
    parity_en = 1'b0; mon_par_en = 1'b0;

    // Overflow: 10 consecutive SPI writes. The first is popped on the second
    // edge, the next eight fill the queue, the tenth is dropped.
    base = spi_dn;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_prot = 1'b0; wr_dat = 8'h80 + 8'(i);
      if (i < 9) exp_q.push_back('{1'b0, 8'h80 + 8'(i), 1'b0});
      @(negedge clk);
      if (i == 8) begin
        check("ovf_count_peak", 32'(fifo_count), 32'd8);
        check("ovf_full",       32'(fifo_full),  32'd1);
        check("ovf_not_yet",    32'(ovf_err),    32'd0);
      end
    end
    check("ovf_set",         32'(ovf_err),    32'd1);
    check("ovf_count_held",  32'(fifo_count), 32'd8);
    wr_dat = 8'h8A; clr_err = 1'b1;          // overflow and clear together
    @(negedge clk);
    check("ovf_set_beats_clr", 32'(ovf_err), 32'd1);
    wr_en = 1'b0;
    @(negedge clk);
    clr_err = 1'b0;
    check("ovf_cleared", 32'(ovf_err), 32'd0);
    expect_frames(9);
    repeat (4) @(negedge clk);
    check("ovf_spi_done_pulses", 32'(spi_dn - base), 32'd9);
    check("ovf_drained_empty",   32'(fifo_empty),    32'd1);

    // Mixed queue: SPI, UART, SPI in write order
    send(1'b0, 8'h11);
    send(1'b1, 8'h22);
    send(1'b0, 8'h33);
    expect_frames(3);
    check("mixed_no_overlap", 32'(overlap), 32'd0);

    // Reset in the middle of a UART data bit, with another word queued
    send(1'b1, 8'h0F);
    send(1'b0, 8'h77);
    exp_q.delete();
    waited = 0;
    while (uart_tx !== 1'b0 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("abort_start_seen", 32'(uart_tx), 32'd0);
    repeat (3 * UDIV + 4) @(negedge clk);
    ubase = uart_dn;
    rst = 1'b0;
    #1;
    check("abort_uart_tx", 32'(uart_tx),    32'd1);
    check("abort_busy",    32'(busy),       32'd0);
    check("abort_empty",   32'(fifo_empty), 32'd1);
    check("abort_count",   32'(fifo_count), 32'd0);
    check("abort_cs",      32'(cs),         32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (300) @(negedge clk);
    check("abort_no_uart_done", 32'(uart_dn - ubase), 32'd0);
    check("abort_no_frames",    32'(obs_q.size()),    32'd0);
    check("abort_stays_idle",   32'({cs, uart_tx, busy}), 32'b110);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_proto_tx_engine.md
# multi_proto_tx_engine

Parametrised, FIFO-buffered serial transmit engine serving SPI-master and UART-transmit traffic from one queue. Each queued word carries its own protocol tag, so SPI and UART transfers interleave in write order without the host waiting on `done` per word. Sits between the host load interface and the serial pins, replacing single-word, fixed-width transmit paths with generalised data width, queue depth and rate dividers, plus overflow detection and optional UART parity.

## Interface
- `DATA_W`, 8: bits per word (SPI and UART payload), ≥2.
- `FIFO_DEPTH`, 8: queue entries, power of two, ≥2.
- `SPI_DIV`, 4: clk cycles per SCLK half-period, ≥1.
- `UART_DIV`, 16: clk cycles per UART bit, ≥2.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `wr_en` in 1: push `{wr_prot, wr_dat}` into FIFO.
- `wr_prot` in 1: 0 = SPI, 1 = UART.
- `wr_dat` in DATA_W: payload.
- `spi_mode` in 2: {CPOL, CPHA}; sampled at pop.
- `parity_en` in 1: UART even-parity bit enable; sampled at pop.
- `clr_err` in 1: clears `ovf_err`.
- `fifo_full`, `fifo_empty` out 1: queue status.
- `fifo_count` out clog2(FIFO_DEPTH)+1: occupancy.
- `busy` out 1: FSM not in IDLE.
- `cs` out 1: SPI chip select, active-low.
- `sclk` out 1: SPI clock.
- `mosi` out 1: SPI data, MSB first.
- `uart_tx` out 1: UART line, idle high, LSB first.
- `spi_done`, `uart_done` out 1: one-cycle completion pulses.
- `ovf_err` out 1: sticky; a write was dropped.

## Operation
- Reset (async, `rst`=0): FIFO empty, pointers 0; `fifo_empty`=1, `fifo_full`=0, `fifo_count`=0, `busy`=0, `cs`=1, `sclk`=0, `mosi`=0, `uart_tx`=1, `spi_done`=`uart_done`=0, `ovf_err`=0, latched mode 0. Reset mid-transfer aborts immediately; no done pulse.
- FIFO: pointers with extra wrap bit; full = MSBs differ, low bits equal. Write while full with no pop that cycle: dropped, `ovf_err` set. Write while full with simultaneous pop: accepted. No bypass; empty FIFO write is popped next cycle. `clr_err` and same-cycle overflow: set wins.
- FSM states: IDLE, SPI_SETUP, SPI_SHIFT, SPI_HOLD, U_START, U_DATA, U_PAR, U_STOP.
- IDLE: if not empty, pop; latch word, tag, `spi_mode`, `parity_en`; next state SPI_SETUP or U_START.
- SPI_SETUP (SPI_DIV cycles): `cs`=0, `sclk`=CPOL, `mosi`=MSB if CPHA=0.
- SPI_SHIFT: 2·DATA_W half-periods of SPI_DIV cycles, `sclk` toggling. CPHA=0: data changes on trailing edges, first bit valid before first edge. CPHA=1: data changes on leading edges. Last edge returns `sclk` to CPOL.
- SPI_HOLD (SPI_DIV cycles): `cs` low, `sclk`=CPOL; exit raises `cs`, pulses `spi_done`, returns to IDLE.
- UART: U_START `uart_tx`=0; U_DATA DATA_W bits LSB first; U_PAR (only if parity_en) even parity = XOR of payload; U_STOP `uart_tx`=1. Each bit UART_DIV cycles. Exit pulses `uart_done`, returns to IDLE.
- Inactive interface stays idle during other protocol's transfer (`cs`=1, `uart_tx`=1).

## Timing
- Write at edge 0 into empty FIFO: `fifo_empty` low after edge 0; pop at edge 1; `cs` low (or start bit) after edge 2.
- SPI `cs` low duration: SPI_DIV·(2·DATA_W+2) cycles (72 at defaults).
- UART frame: UART_DIV·(DATA_W+2+parity_en) cycles (160/176 at defaults).
- Done pulse coincides with first IDLE cycle; back-to-back words: ≥1 IDLE cycle with `cs`=1 between SPI frames; next UART start bit follows stop bit by 1 cycle.
- `fifo_count`, flags update the edge after write/pop.

## Test plan
- SPI mode 0, 0xA5, defaults -> `mosi` 1,0,1,0,0,1,0,1 sampled on 8 rising `sclk` edges; `cs` low 72 cycles; one `spi_done` pulse.
- SPI mode 3, 0x3C -> `sclk` idles high, slave model capturing on rising edges reads 0x3C.
- UART 0x55, parity_en=1 -> `uart_tx` 0,1,0,1,0,1,0,1,0,0(parity),1, each 16 cycles, 176 total, one `uart_done`.
- Write 10 SPI words on consecutive cycles from empty -> word 10 dropped, `ovf_err`=1, `fifo_count` peaks at 8, exactly 9 `spi_done` pulses; `clr_err` clears flag.
- Queue SPI 0x11, UART 0x22, SPI 0x33 -> transfers in order, never overlapping, correct payloads.
- Assert `rst` mid-UART data bit -> `uart_tx`=1, `busy`=0, FIFO empty immediately; no `uart_done`.
